data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Multi-cycle data memory that answers CPU load/store requests over a valid/ready request channel and a single-cycle response pulse. It replaces the zero-latency data memory at the far end of the MEM stage. While a request is outstanding it raises `stall`, which the hazard unit uses to hold the pipeline. It supports word and byte accesses and flags misaligned or out-of-range addresses.

## Interface
- `DEPTH_WORDS`, 256: number of 16-bit words; byte address range is 0 .. 2*DEPTH_WORDS-1.
- `WAIT_CYCLES`, 2: wait states between acceptance and response; legal range 0..15.

- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept.
- `req_write`  in  1  1 = store, 0 = load.
- `req_byte_en`  in  1  1 = byte access, 0 = word access.
- `req_addr`  in  16  byte address.
- `req_wdata`  in  16  store data; byte stores use bits [7:0].
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_rdata`  out  16  load data, valid only with `resp_valid`.
- `resp_error`  out  1  request was misaligned or out of range, valid with `resp_valid`.
- `stall`  out  1  pipeline hold request.

## Operation
- States are IDLE, WAIT and RESP.
- **IDLE:** `req_ready`=1. On `req_valid`, latch write, byte_en, addr and wdata, load the wait counter with `WAIT_CYCLES`, and go to WAIT. If `WAIT_CYCLES`=0, go directly to RESP.
- **WAIT:** decrement the counter each cycle. On the cycle the counter reads 1, go to RESP. That edge is the commit edge.
- **RESP:** `resp_valid`=1 for exactly one cycle, then return to IDLE. `req_ready`=0 in WAIT and RESP.
- Latched request fields are frozen after acceptance. Input changes during WAIT or RESP are ignored.
- **Error check** (evaluated on the latched request):
  - A word access with addr[0]=1 is an error.
  - addr[15:1] ≥ `DEPTH_WORDS` is an error.
  - On error: no write, `resp_rdata`=0, `resp_error`=1.
- **Word load:** `resp_rdata` = mem[addr[15:1]].
- **Byte load:** zero-extended selected lane. addr[0]=0 selects [7:0]; addr[0]=1 selects [15:8].
- **Word store:** mem[addr[15:1]] ← wdata.
- **Byte store:** only the selected lane ← wdata[7:0]; the other lane is unchanged.
- **Loads on stores:** `resp_rdata`=0 on a store response.
- Read data is captured on the commit edge. The write is performed on the commit edge.
- `stall` = (IDLE & `req_valid`) | WAIT.

## Timing
- **Reset** (asynchronous, `reset`=0):
  - State goes to IDLE and the counter clears.
  - Memory array is zeroed.
  - `req_ready`=1; `resp_valid`=0, `resp_rdata`=0, `resp_error`=0.
  - `stall`=0 while `req_valid`=0.
- **Latency:** acceptance edge to `resp_valid` high is `WAIT_CYCLES`+1 cycles. `stall` is high from the acceptance cycle through the cycle before `resp_valid`, and low during the RESP cycle.
- **Throughput:** one request per `WAIT_CYCLES`+2 cycles. A request held high across RESP is accepted in the following IDLE cycle.
- **Reset mid-operation:** any outstanding request is dropped. If reset occurs before the commit edge, there is no write and no response.
- **Counter:** 4 bits. No wrap; it stops at the transition to RESP.
- `resp_rdata`/`resp_error` hold their value outside `resp_valid`, but they are defined only while `resp_valid`=1.

## Structure
- Shared package `mem_pkg` holds:
  - the state enum (IDLE, WAIT, RESP);
  - lane-select constants LANE_LO=0 and LANE_HI=1;
  - the `WAIT_CYCLES` maximum (15).
- One sub-module, `byte_lane_merge`, is combinational. It takes the old word, wdata[7:0], lane and byte_en, and outputs the merged write word. It is also used to extract the read lane.
- All other logic (FSM, counter, request latch, array) lives in `data_mem_responder`.

## Test plan
- Reset, then a word store to 0x0010 of 0xBEEF, then a word load from 0x0010 (`WAIT_CYCLES`=2) → `resp_valid` 3 cycles after each acceptance; load returns 0xBEEF; `resp_error`=0; `stall` high for 3 cycles per request.
- Byte store of 0x12 to 0x0011 over 0xBEEF, then byte loads from 0x0011 and 0x0010 → word becomes 0x12EF; byte loads return 0x0012 and 0x00EF.
- Word load from 0x0003, and a store to 0x0200 with `DEPTH_WORDS`=256 → `resp_error`=1, `resp_rdata`=0, memory unchanged.
- `WAIT_CYCLES`=0 with back-to-back requests, `req_valid` held high → `resp_valid` the cycle after each acceptance; acceptances every 2 cycles; `req_ready` toggles 1,0.
- Store of 0x5555 to 0x0020, with `reset` asserted during WAIT, then a load from 0x0020 after release → no response to the dropped store; load returns 0x0000.
- Change `req_addr`/`req_wdata` during WAIT → the response reflects the latched values only.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the multi-cycle data memory responder.
//
// Contents:
//   state_t          - responder FSM states (IDLE, WAIT, RESP)
//   LANE_LO/LANE_HI  - byte lane selectors (addr[0] = 0 / 1)
//   WAIT_CYCLES_MAX  - largest number of wait states the 4-bit counter holds
//   lane_of()        - maps a byte address to its lane selector
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;

  localparam int WAIT_CYCLES_MAX = 15;

  function automatic logic lane_of(input logic [15:0] byte_addr);
    return byte_addr[0] ? LANE_HI : LANE_LO;
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational byte-lane helper for the data memory.
//
// Builds the word to be written back (full word for word stores, old word
// with one lane replaced for byte stores) and extracts the addressed lane
// of the old word, zero-extended, for byte loads.
//
// Ports:
//   old_word    in  16  current contents of the addressed memory word
//   wdata       in  16  store data; byte stores use bits [7:0]
//   lane        in  1   LANE_LO selects [7:0], LANE_HI selects [15:8]
//   byte_en     in  1   1 = byte access, 0 = word access
//   merged_word out 16  word to write back on a store
//   read_lane   out 16  selected lane of old_word, zero-extended
module byte_lane_merge
  import mem_pkg::*;
(
  input  logic [15:0] old_word,
  input  logic [15:0] wdata,
  input  logic        lane,
  input  logic        byte_en,
  output logic [15:0] merged_word,
  output logic [15:0] read_lane
);

  always_comb begin
    merged_word = wdata;
    if (byte_en) begin
      merged_word = old_word;
      if (lane == LANE_HI) merged_word[15:8] = wdata[7:0];
      else                 merged_word[7:0]  = wdata[7:0];
    end
  end

  always_comb begin
    read_lane = {8'h00, (lane == LANE_HI) ? old_word[15:8] : old_word[7:0]};
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory answering CPU load/store requests.
//
// A request is accepted in IDLE (req_ready=1), held for WAIT_CYCLES wait
// states, then answered with a one-cycle resp_valid pulse. Word and byte
// accesses are supported; misaligned word accesses and out-of-range word
// indices are answered with resp_error=1, rdata=0 and no write.
//
// Parameters:
//   DEPTH_WORDS  number of 16-bit words (byte range 0 .. 2*DEPTH_WORDS-1)
//   WAIT_CYCLES  wait states between acceptance and response (0..15)
//
// Ports:
//   clock       in  1   rising-edge clock
//   reset       in  1   asynchronous, active-low reset
//   req_valid   in  1   request present
//   req_ready   out 1   responder can accept (IDLE)
//   req_write   in  1   1 = store, 0 = load
//   req_byte_en in  1   1 = byte access, 0 = word access
//   req_addr    in  16  byte address
//   req_wdata   in  16  store data
//   resp_valid  out 1   one-cycle response pulse
//   resp_rdata  out 16  load data (0 for stores and errors)
//   resp_error  out 1   misaligned or out-of-range request
//   stall       out 1   pipeline hold: (IDLE & req_valid) | WAIT
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte_en,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_error,
  output logic        stall
);

  localparam int ADDR_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > WAIT_CYCLES_MAX) ?
                                     4'(WAIT_CYCLES_MAX) : 4'(WAIT_CYCLES);

  state_t state, next_state;
  logic [3:0]  wait_cnt;
  logic        lat_write;
  logic        lat_byte_en;
  logic [15:0] lat_addr;
  logic [15:0] lat_wdata;
  logic [15:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        commit;
  logic        eff_write;
  logic        eff_byte_en;
  logic [15:0] eff_addr;
  logic [15:0] eff_wdata;
  logic [14:0] word_idx;
  logic [ADDR_W-1:0] mem_idx;
  logic        req_err;
  logic [15:0] old_word;
  logic [15:0] merged_word;
  logic [15:0] read_lane;

  // With zero wait states the commit edge is the acceptance edge, so the
  // request has to be taken straight from the inputs instead of the latch.
  always_comb begin
    accept      = (state == IDLE) && req_valid;
    commit      = (accept && (WAIT_INIT == 4'd0)) ||
                  ((state == WAIT) && (wait_cnt == 4'd1));
    eff_write   = (state == IDLE) ? req_write   : lat_write;
    eff_byte_en = (state == IDLE) ? req_byte_en : lat_byte_en;
    eff_addr    = (state == IDLE) ? req_addr    : lat_addr;
    eff_wdata   = (state == IDLE) ? req_wdata   : lat_wdata;
    word_idx    = eff_addr[15:1];
    mem_idx     = word_idx[ADDR_W-1:0];
    req_err     = (!eff_byte_en && eff_addr[0]) ||
                  ({17'd0, word_idx} >= 32'(DEPTH_WORDS));
    old_word    = mem[mem_idx];
  end

  byte_lane_merge u_lane (
    .old_word    (old_word),
    .wdata       (eff_wdata),
    .lane        (lane_of(eff_addr)),
    .byte_en     (eff_byte_en),
    .merged_word (merged_word),
    .read_lane   (read_lane)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; WAIT is skipped entirely when there are no wait states.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (req_valid) next_state = (WAIT_INIT == 4'd0) ? RESP : WAIT;
      WAIT: if (wait_cnt == 4'd1) next_state = RESP;
      RESP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake and pipeline-hold outputs.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    stall      = accept || (state == WAIT);
  end

  // Request latch and wait counter. The counter reaches 0 exactly on the
  // transition into RESP and is not touched again until the next acceptance.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt    <= '0;
      lat_write   <= 1'b0;
      lat_byte_en <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
    end else if (accept) begin
      wait_cnt    <= WAIT_INIT;
      lat_write   <= req_write;
      lat_byte_en <= req_byte_en;
      lat_addr    <= req_addr;
      lat_wdata   <= req_wdata;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Response data is captured on the commit edge and held until the next one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else if (commit) begin
      resp_error <= req_err;
      if (req_err || eff_write) resp_rdata <= '0;
      else if (eff_byte_en)     resp_rdata <= read_lane;
      else                      resp_rdata <= old_word;
    end
  end

  // Storage array; cleared by reset, written only by error-free stores.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (commit && eff_write && !req_err) begin
      mem[mem_idx] <= merged_word;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder. Two instances are exercised:
// dut 0 with two wait states and dut 1 with none. Requests are issued by
// apply_stimulus, which asks a behavioural memory model for the expected
// answer and queues it with the cycle it is due; an independent monitor
// compares every response pulse against the head of the queue.
module tb_data_mem_responder;

  localparam int DEPTH = 256;
  localparam int WC0   = 2;
  localparam int WC1   = 0;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid   [2];
  logic        req_write   [2];
  logic        req_byte_en [2];
  logic [15:0] req_addr    [2];
  logic [15:0] req_wdata   [2];
  logic        req_ready   [2];
  logic        resp_valid  [2];
  logic [15:0] resp_rdata  [2];
  logic        resp_error  [2];
  logic        stall       [2];

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   stall_cnt [2];
  exp_t exp_q0 [$];
  exp_t exp_q1 [$];
  exp_t mon_e;
  logic [15:0] ref_mem [2][DEPTH];

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC0)) dut0 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_byte_en(req_byte_en[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
    .resp_error(resp_error[0]), .stall(stall[0])
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC1)) dut1 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_byte_en(req_byte_en[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
    .resp_error(resp_error[1]), .stall(stall[1])
  );

  function automatic int wait_of(input int d);
    return (d == 0) ? WC0 : WC1;
  endfunction

  task automatic check_output(input string name, input logic [15:0] act,
                              input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural memory: plain word array, lanes handled by shifts and masks.
  function automatic void ref_access(input int d, input logic wr, input logic be,
                                     input logic [15:0] addr, input logic [15:0] wdata,
                                     output logic [15:0] rdata, output logic err);
    int widx;
    bit hi;
    widx  = int'(addr) / 2;
    hi    = (int'(addr) % 2) == 1;
    err   = (!be && hi) || (widx >= DEPTH);
    rdata = 16'h0000;
    if (!err) begin
      if (wr) begin
        if (!be)     ref_mem[d][widx] = wdata;
        else if (hi) ref_mem[d][widx] = (ref_mem[d][widx] & 16'h00FF) | ((wdata & 16'h00FF) << 8);
        else         ref_mem[d][widx] = (ref_mem[d][widx] & 16'hFF00) | (wdata & 16'h00FF);
      end else if (!be) rdata = ref_mem[d][widx];
      else if (hi)      rdata = ref_mem[d][widx] >> 8;
      else              rdata = ref_mem[d][widx] & 16'h00FF;
    end
  endfunction

  function automatic void clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++) ref_mem[d][i] = 16'h0000;
  endfunction

  // Issue one request; on acceptance the expected response is queued. With
  // hold=0 the request fields are scrambled right after acceptance, which
  // the responder must ignore.
  task automatic apply_stimulus(input int d, input logic wr, input logic be,
                                input logic [15:0] addr, input logic [15:0] wdata,
                                input bit hold, output int acc_cyc);
    int          waited;
    logic [15:0] rd;
    logic        er;
    exp_t        e;
    acc_cyc = -1;
    @(negedge clock);
    req_write[d]   = wr;
    req_byte_en[d] = be;
    req_addr[d]    = addr;
    req_wdata[d]   = wdata;
    req_valid[d]   = 1'b1;
    waited = 0;
    while (!req_ready[d] && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (!req_ready[d]) begin
      check_output("accept_timeout", 16'(req_ready[d]), 16'd1);
      req_valid[d] = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    acc_cyc = cyc;
    ref_access(d, wr, be, addr, wdata, rd, er);
    e.rdata = rd;
    e.err   = er;
    e.due   = cyc + wait_of(d);
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    if (!hold) begin
      req_valid[d]   = 1'b0;
      req_write[d]   = 1'($urandom);
      req_byte_en[d] = 1'($urandom);
      req_addr[d]    = 16'($urandom);
      req_wdata[d]   = 16'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (exp_q0.size() != 0 || exp_q1.size() != 0)
      check_output("drain_timeout", 16'(exp_q0.size() + exp_q1.size()), 16'd0);
    @(negedge clock);
  endtask

  // Monitor: samples a little after the falling edge so that inputs driven
  // on that edge have settled.
  always @(negedge clock) begin
    #2;
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        stall_cnt[d] = 0;
      end else begin
        if (stall[d]) stall_cnt[d]++;
        if (resp_valid[d]) begin
          if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
            check_output("unexpected_resp", 16'(d), 16'hFFFF);
          end else begin
            mon_e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check_output("resp_rdata", resp_rdata[d], mon_e.rdata);
            check_output("resp_error", 16'(resp_error[d]), 16'(mon_e.err));
            check_output("resp_cycle", 16'(cyc), 16'(mon_e.due));
            check_output("stall_cycles", 16'(stall_cnt[d]), 16'(wait_of(d) + 1));
            check_output("stall_in_resp", 16'(stall[d]), 16'd0);
            check_output("ready_in_resp", 16'(req_ready[d]), 16'd0);
          end
          stall_cnt[d] = 0;
        end
      end
    end
  end

  // Directed plan first, then random traffic, mid-request reset, and
  // zero-wait back-to-back requests with req_valid held high.
  initial begin
    int a;
    int prev;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_byte_en[d] = 1'b0;
      req_addr[d] = 16'h0000; req_wdata[d] = 16'h0000; stall_cnt[d] = 0;
    end
    clear_model();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    #3;
    for (int d = 0; d < 2; d++) begin
      check_output("rst_ready", 16'(req_ready[d]), 16'd1);
      check_output("rst_resp_valid", 16'(resp_valid[d]), 16'd0);
      check_output("rst_rdata", resp_rdata[d], 16'h0000);
      check_output("rst_error", 16'(resp_error[d]), 16'd0);
      check_output("rst_stall", 16'(stall[d]), 16'd0);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #3;
    check_output("idle_stall", 16'(stall[0]), 16'd0);

    $display("[TB] directed word/byte/error accesses, WAIT_CYCLES=2");
    apply_stimulus(0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 1'b0, a);
    apply_stimulus(0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, a);
    apply_stimulus(0, 1'b1, 1'b1, 16'h0011, 16'h3412, 1'b0, a);
    apply_stimulus(0, 1'b0, 1'b1, 16'h0011, 16'h0000, 1'b0, a);
    apply_stimulus(0, 1'b0, 1'b1, 16'h0010, 16'h0000, 1'b0, a);
    apply_stimulus(0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, a);
    apply_stimulus(0, 1'b0, 1'b0, 16'h0003, 16'h0000, 1'b0, a);
    apply_stimulus(0, 1'b1, 1'b0, 16'h0200, 16'hFFFF, 1'b0, a);
    apply_stimulus(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, a);
    apply_stimulus(0, 1'b1, 1'b0, 16'h01FE, 16'hA5C3, 1'b0, a);
    apply_stimulus(0, 1'b0, 1'b1, 16'h01FF, 16'h0000, 1'b0, a);
    apply_stimulus(0, 1'b1, 1'b1, 16'h0201, 16'h00FF, 1'b0, a);

    $display("[TB] random traffic, WAIT_CYCLES=2");
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra;
      ra = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
      apply_stimulus(0, 1'($urandom), 1'($urandom), ra, 16'($urandom), 1'b0, a);
    end
    drain();

    $display("[TB] reset during WAIT drops the store");
    req_write[0] = 1'b1; req_byte_en[0] = 1'b0;
    req_addr[0] = 16'h0020; req_wdata[0] = 16'h5555; req_valid[0] = 1'b1;
    @(posedge clock);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    clear_model();
    #1;
    check_output("midrst_ready", 16'(req_ready[0]), 16'd1);
    check_output("midrst_stall", 16'(stall[0]), 16'd0);
    check_output("midrst_resp_valid", 16'(resp_valid[0]), 16'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    apply_stimulus(0, 1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, a);
    apply_stimulus(0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, a);
    drain();

    $display("[TB] back-to-back requests with req_valid held, WAIT_CYCLES=0");
    prev = -1;
    apply_stimulus(1, 1'b1, 1'b0, 16'h0004, 16'h1234, 1'b1, prev);
    apply_stimulus(1, 1'b0, 1'b0, 16'h0004, 16'hFFFF, 1'b1, a);
    check_output("throughput", 16'(a - prev), 16'd2);
    prev = a;
    for (int i = 0; i < 20; i++) begin
      logic [15:0] ra;
      ra = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
      apply_stimulus(1, 1'($urandom), 1'($urandom), ra, 16'($urandom), 1'b1, a);
      check_output("throughput", 16'(a - prev), 16'd2);
      prev = a;
    end
    req_valid[1] = 1'b0;
    drain();
    repeat (3) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
